// File: rtl/param_down_timer.sv
// Programmable mod-N down-counting timer with one-shot and periodic (auto-reload) modes.
// Counts a loaded value down to zero on enabled ticks and flags terminal count.
module param_down_timer #(
  parameter  int MOD = 100000,
  localparam int W   = $clog2(MOD)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic         i_mode,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_tc,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

  state_t       state;
  logic [W-1:0] reload_reg;
  logic         mode_reg;
  logic [W-1:0] load_clamped;

  always_comb begin
    load_clamped = (i_load_val > MAX_VAL) ? MAX_VAL : i_load_val;
  end

  // Command priority is load > stop > start > tick; a command that has no
  // effect in the current state falls through to the next one.
  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch reads the pre-edge values of state and o_count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      o_count    <= '0;
      reload_reg <= MAX_VAL;
      mode_reg   <= 1'b0;
      o_tc       <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_tc <= 1'b0;
      if (i_load) begin
        reload_reg <= load_clamped;
        o_count    <= load_clamped;
        state      <= IDLE;
        o_busy     <= 1'b0;
        o_done     <= 1'b0;
      end else if (i_stop && state == RUN) begin
        state <= PAUSE;
      end else if (i_stop && state == PAUSE) begin
        state   <= IDLE;
        o_busy  <= 1'b0;
        o_count <= reload_reg;
      end else if (i_start && state != RUN) begin
        state  <= RUN;
        o_busy <= 1'b1;
        if (state != PAUSE) begin
          o_count  <= reload_reg;
          mode_reg <= i_mode;
          o_done   <= 1'b0;
        end
      end else if (state == RUN && i_en) begin
        if (o_count != '0) begin
          o_count <= o_count - 1'b1;
        end else begin
          o_tc <= 1'b1;
          if (mode_reg) begin
            o_count <= reload_reg;
          end else begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_param_down_timer.sv
// Self-checking bench for param_down_timer (MOD = 10): directed scenarios with
// fixed expectations plus a randomized run checked against a behavioural model.
module tb_param_down_timer;

  localparam int MOD = 10;
  localparam int W   = $clog2(MOD);

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_load = 1'b0;
  logic [W-1:0] i_load_val = '0;
  logic         i_start = 1'b0;
  logic         i_stop = 1'b0;
  logic         i_mode = 1'b0;
  logic         i_en = 1'b0;
  logic [W-1:0] o_count;
  logic         o_tc;
  logic         o_busy;
  logic         o_done;

  int checks = 0;
  int errors = 0;

  // Behavioural model: activity flags and plain integer arithmetic.
  bit m_running, m_paused, m_finished, m_periodic, m_tc;
  int m_count, m_reload;

  param_down_timer #(.MOD(MOD)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (i_load),
    .i_load_val (i_load_val),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_mode     (i_mode),
    .i_en       (i_en),
    .o_count    (o_count),
    .o_tc       (o_tc),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs in effect at this edge.
  task automatic model_update();
    if (i_rst) begin
      m_running = 0; m_paused = 0; m_finished = 0; m_periodic = 0; m_tc = 0;
      m_count = 0; m_reload = MOD - 1;
    end else begin
      m_tc = 0;
      if (i_load) begin
        m_reload = (int'(i_load_val) > MOD - 1) ? MOD - 1 : int'(i_load_val);
        m_count = m_reload;
        m_running = 0; m_paused = 0; m_finished = 0;
      end else if (i_stop && m_running) begin
        m_running = 0; m_paused = 1;
      end else if (i_stop && m_paused) begin
        m_paused = 0; m_count = m_reload;
      end else if (i_start && !m_running) begin
        if (!m_paused) begin
          m_count = m_reload; m_periodic = i_mode; m_finished = 0;
        end
        m_paused = 0; m_running = 1;
      end else if (m_running && i_en) begin
        if (m_count > 0) m_count = m_count - 1;
        else begin
          m_tc = 1;
          if (m_periodic) m_count = m_reload;
          else begin
            m_running = 0; m_finished = 1;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge i_clk);
    model_update();
    #1;
    chk("model_count", 32'(o_count), 32'(m_count));
    chk("model_tc", 32'(o_tc), 32'(m_tc));
    chk("model_busy", 32'(o_busy), 32'(m_running | m_paused));
    chk("model_done", 32'(o_done), 32'(m_finished));
  endtask

  task automatic step(input bit ld, input int val, input bit st, input bit sp,
                      input bit md, input bit en);
    logic [31:0] v;
    v = 32'(val);
    i_load = ld; i_load_val = v[W-1:0]; i_start = st; i_stop = sp;
    i_mode = md; i_en = en;
    cycle();
  endtask

  initial begin
    // Reset, then reset mid-run at count 5
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_busy", 32'(o_busy), 0);
    i_rst = 1'b0;
    step(0, 0, 1, 0, 0, 1);
    chk("rst_first_start", 32'(o_count), 9);
    repeat (4) step(0, 0, 0, 0, 0, 1);
    chk("count_at_5", 32'(o_count), 5);
    i_rst = 1'b1;
    step(0, 0, 0, 0, 0, 1);
    chk("midrun_rst_count", 32'(o_count), 0);
    chk("midrun_rst_tc", 32'(o_tc), 0);
    chk("midrun_rst_busy", 32'(o_busy), 0);
    chk("midrun_rst_done", 32'(o_done), 0);
    i_rst = 1'b0;
    step(0, 0, 1, 0, 0, 1);
    chk("post_rst_start", 32'(o_count), 9);

    // One-shot, load 3
    step(1, 3, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    chk("os_k1", 32'(o_count), 3);
    for (int i = 2; i >= 0; i--) begin
      step(0, 0, 0, 0, 0, 1);
      chk("os_seq", 32'(o_count), 32'(i));
      chk("os_no_tc", 32'(o_tc), 0);
    end
    step(0, 0, 0, 0, 0, 1);
    chk("os_tc", 32'(o_tc), 1);
    chk("os_done", 32'(o_done), 1);
    chk("os_busy_low", 32'(o_busy), 0);
    step(0, 0, 0, 0, 0, 1);
    chk("os_tc_width", 32'(o_tc), 0);
    chk("os_done_hold", 32'(o_done), 1);
    chk("os_count_hold", 32'(o_count), 0);

    // Periodic, load 2: 1,0,2(tc),1,0,2(tc)...
    step(1, 2, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("per_count", 32'(o_count), (i % 3 == 0) ? 1 : (i % 3 == 1) ? 0 : 2);
      chk("per_tc", 32'(o_tc), (i % 3 == 2) ? 1 : 0);
    end

    // Periodic with i_en toggling: tc every 6 cycles
    step(1, 2, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 18; i++) begin
      step(0, 0, 0, 0, 0, (i % 2 == 0));
      chk("gate_tc", 32'(o_tc), (i % 6 == 4) ? 1 : 0);
    end

    // Clamp and reload-0 edges
    step(1, 15, 0, 0, 0, 1);
    chk("clamp", 32'(o_count), 9);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 1);
    chk("r0p_start_tc", 32'(o_tc), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("r0p_tc", 32'(o_tc), 1);
    end
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("r0o_tc", 32'(o_tc), 1);
    chk("r0o_done", 32'(o_done), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("r0o_tc_once", 32'(o_tc), 0);

    // Pause / resume / abort
    step(1, 9, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1);
    chk("pause_pre", 32'(o_count), 6);
    step(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("pause_hold", 32'(o_count), 6);
      chk("pause_busy", 32'(o_busy), 1);
    end
    step(0, 0, 1, 0, 0, 1);
    chk("resume_no_tick", 32'(o_count), 6);
    step(0, 0, 0, 0, 0, 1);
    chk("resume_5", 32'(o_count), 5);
    step(0, 0, 0, 0, 0, 1);
    chk("resume_4", 32'(o_count), 4);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    chk("abort_count", 32'(o_count), 9);
    chk("abort_busy", 32'(o_busy), 0);

    // Priority
    step(1, 4, 1, 0, 0, 1);
    chk("prio_load_count", 32'(o_count), 4);
    chk("prio_load_busy", 32'(o_busy), 0);
    step(0, 0, 0, 0, 0, 1);
    chk("prio_load_norun", 32'(o_count), 4);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("prio_run_3", 32'(o_count), 3);
    step(0, 0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("prio_stop_pause", 32'(o_count), 3);
    chk("prio_stop_busy", 32'(o_busy), 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    chk("prio_start_ignored", 32'(o_count), 2);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      i_rst = ($urandom_range(0, 199) == 0);
      step(($urandom_range(0, 19) == 0), int'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 14) == 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
    end
    i_rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_down_timer.md
Name: param_down_timer

Overview:
- Programmable mod-N down-counting timer; counterpart to the free-running mod-N up counter.
- Counts a loaded value down to zero on enabled ticks and reports terminal count.
- Supports one-shot and periodic (auto-reload) operation, plus pause/resume.
- Used as a timeout and interval generator alongside the existing counter blocks.

Parameters:
- MOD, 100000, counter modulus. Maximum reload value is MOD-1. Counter width W = $clog2(MOD). MOD >= 2 is required.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_load  input  1  load strobe for i_load_val.
- i_load_val  input  W  reload value.
- i_start  input  1  start/resume strobe.
- i_stop  input  1  pause/abort strobe.
- i_mode  input  1  0 = one-shot, 1 = periodic; sampled when i_start is accepted.
- i_en  input  1  tick enable (prescaler strobe); count changes only when high.
- o_count  output  W  current count value.
- o_tc  output  1  one-cycle terminal-count pulse.
- o_busy  output  1  high in RUN or PAUSE.
- o_done  output  1  one-shot completion level; high in DONE.

Behaviour:
- Reset:
  - state = IDLE, o_count = 0, reload_reg = MOD-1, mode_reg = 0.
  - o_tc, o_busy and o_done are all 0.
  - Reset overrides everything, including mid-run.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Command priority per cycle: i_load > i_stop > i_start > tick.
- i_load (any state):
  - reload_reg <= min(i_load_val, MOD-1), i.e. values above MOD-1 clamp to MOD-1.
  - o_count <= the same clamped value.
  - state -> IDLE; o_done <= 0; o_tc <= 0.
- i_start:
  - From IDLE or DONE: o_count <= reload_reg, mode_reg <= i_mode, o_done <= 0, state -> RUN.
  - From PAUSE: state -> RUN; count is kept and mode_reg is unchanged.
  - In RUN: ignored.
- i_stop:
  - In RUN: state -> PAUSE; count holds.
  - In PAUSE: state -> IDLE and o_count <= reload_reg.
  - In IDLE or DONE: ignored.
- RUN with i_en = 1:
  - o_count != 0: o_count <= o_count - 1.
  - o_count == 0, periodic: o_tc <= 1, o_count <= reload_reg, stay in RUN.
  - o_count == 0, one-shot: o_tc <= 1, o_done <= 1, o_count stays 0, state -> DONE.
- RUN with i_en = 0: hold. No tick happens in the start cycle itself.
- Timing:
  - The interval is reload+1 enabled ticks. o_tc rises in the cycle after the enabled tick that sees count 0.
  - o_tc is exactly 1 cycle wide and is 0 in every other cycle.
  - Reload 0 in periodic mode gives o_tc on every cycle following an enabled tick.
- i_en is ignored outside RUN. A tick coinciding with i_stop or i_load is lost; the command takes effect instead.
- o_count never exceeds MOD-1. Subtraction never wraps below 0.

Test Plan (MOD = 10, i_en = 1 unless stated):
- Reset: assert i_rst mid-run with count 5 -> next cycle o_count = 0, o_tc/o_busy/o_done = 0, state IDLE; a subsequent start without load counts from 9.
- One-shot: load 3, start with mode 0 at cycle k -> o_count = 3,2,1,0 at k+1..k+4; o_tc = 1 only at k+5; o_done = 1 from k+5; o_busy drops at k+5; o_count stays 0.
- Periodic and gating:
  - Load 2, start with mode 1 -> o_tc every 3 cycles for at least 4 periods; count sequence 2,1,0,2,1,0...
  - With i_en toggling 1,0,1,0 -> o_tc every 6 cycles.
- Clamp and reload-0 edges:
  - Load 15 -> o_count = 9.
  - Load 0, periodic -> o_tc high every cycle after start+1.
  - Load 0, one-shot -> o_tc single pulse, o_done = 1.
- Pause/resume: count at 6, pulse i_stop -> o_count holds at 6 for 5 cycles with o_busy = 1. Then:
  - i_start -> resumes 5,4,...
  - Second i_stop instead -> IDLE, o_count = reload, o_busy = 0.
- Priority:
  - i_load(4) + i_start same cycle -> IDLE, o_count = 4, no run.
  - i_stop + i_start in RUN -> PAUSE.
  - i_start while RUN -> ignored, count continues.
